// File: rtl/dino_pkg.sv
// Shared types and default geometry for the dino sprite path (also used by vga_disp).
package dino_pkg;

   localparam int unsigned CoordW  = 10;
   localparam int unsigned VelW    = 7;
   localparam int unsigned VelMagW = 6;
   localparam int unsigned HeightW = 8;

   localparam logic [CoordW-1:0]  DefDinoX   = 10'd80;
   localparam logic [CoordW-1:0]  DefGroundY = 10'd380;
   localparam logic [CoordW-1:0]  DefCeilY   = 10'd0;
   localparam logic [HeightW-1:0] DefStandH  = 8'd40;
   localparam logic [HeightW-1:0] DefDuckH   = 8'd24;
   localparam logic [VelMagW-1:0] DefJumpVel = 6'd14;
   localparam logic [VelMagW-1:0] DefGravity = 6'd1;
   localparam logic [VelMagW-1:0] DefMaxFall = 6'd14;

   typedef enum logic [2:0] {
      StGround,
      StDuck,
      StRise,
      StFall,
      StDead
   } dino_state_e;

endpackage

// File: rtl/dino_jump_ctrl_if.sv
// Frame/button inputs and sprite outputs exchanged between the game logic and dino_jump_ctrl.
interface dino_jump_ctrl_if;
   import dino_pkg::*;

   logic                frame_tick;
   logic                jump_btn;
   logic                duck_btn;
   logic                alive;
   logic [CoordW-1:0]   dino_h;
   logic [CoordW-1:0]   dino_v;
   logic [HeightW-1:0]  dino_height;
   logic                airborne;
   logic                jump_pulse;
   logic                land_pulse;

   modport master (
      output frame_tick, jump_btn, duck_btn, alive,
      input  dino_h, dino_v, dino_height, airborne, jump_pulse, land_pulse
   );

   modport slave (
      input  frame_tick, jump_btn, duck_btn, alive,
      output dino_h, dino_v, dino_height, airborne, jump_pulse, land_pulse
   );

endinterface

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous button with a registered rising-edge strobe.
module btn_sync (
   input  logic clk,
   input  logic clr,
   input  logic btn,
   output logic lvl,
   output logic rise
);

   logic meta_q, sync_q, prev_q, rise_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         meta_q <= btn;
         sync_q <= meta_q;
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
      end
   end

   assign lvl  = sync_q;
   assign rise = rise_q;

endmodule

// File: rtl/dino_jump_ctrl.sv
// Per-frame dino sprite physics (jump, duck, gravity, death freeze) feeding vga_disp.
// Optional FAST_FALL_EN: duck held while airborne doubles the gravity decrement.
module dino_jump_ctrl
   import dino_pkg::*;
#(
   parameter logic [CoordW-1:0]  DINO_X   = DefDinoX,
   parameter logic [CoordW-1:0]  GROUND_Y = DefGroundY,
   parameter logic [CoordW-1:0]  CEIL_Y   = DefCeilY,
   parameter logic [HeightW-1:0] STAND_H  = DefStandH,
   parameter logic [HeightW-1:0] DUCK_H   = DefDuckH,
   parameter logic [VelMagW-1:0] JUMP_VEL = DefJumpVel,
   parameter logic [VelMagW-1:0] GRAVITY  = DefGravity,
   parameter logic [VelMagW-1:0] MAX_FALL = DefMaxFall
) (
   input logic             vgaclk,
   input logic             clr,
   dino_jump_ctrl_if.slave bus
);

   logic jump_rise, jump_lvl_unused;
   logic duck_lvl, duck_rise_unused;

   btn_sync u_jump_sync (
      .clk  (vgaclk),
      .clr  (clr),
      .btn  (bus.jump_btn),
      .lvl  (jump_lvl_unused),
      .rise (jump_rise)
   );

   btn_sync u_duck_sync (
      .clk  (vgaclk),
      .clr  (clr),
      .btn  (bus.duck_btn),
      .lvl  (duck_lvl),
      .rise (duck_rise_unused)
   );

   dino_state_e            state_q, state_d;
   logic signed [VelW-1:0] vel_q, vel_d;
   logic [CoordW-1:0]      pos_q, pos_d;
   logic [HeightW-1:0]     height_q, height_d;
   logic                   jump_pend_q, jump_pend_d;
   logic                   jump_pulse_q, jump_pulse_d;
   logic                   land_pulse_q, land_pulse_d;

   logic                   jump_req;
   logic signed [CoordW:0] next_y;
   logic signed [VelW+1:0] vel_dec, vel_sub, vel_floor, vel_next;

   // A rise landing on the tick cycle itself still counts as a request.
   assign jump_req = jump_pend_q | jump_rise;

   // Positive velocity moves the sprite up, i.e. towards smaller row numbers.
   assign next_y = $signed({1'b0, pos_q})
                   - $signed({{(CoordW + 1 - VelW){vel_q[VelW-1]}}, vel_q});

`ifdef FAST_FALL_EN
   assign vel_dec = duck_lvl ? $signed((VelW + 2)'({GRAVITY, 1'b0}))
                             : $signed((VelW + 2)'(GRAVITY));
`else
   assign vel_dec = $signed((VelW + 2)'(GRAVITY));
`endif

   assign vel_floor = -$signed((VelW + 2)'(MAX_FALL));
   assign vel_sub   = $signed({{2{vel_q[VelW-1]}}, vel_q}) - vel_dec;
   assign vel_next  = (vel_sub < vel_floor) ? vel_floor : vel_sub;

   always_comb begin
      state_d      = state_q;
      vel_d        = vel_q;
      pos_d        = pos_q;
      height_d     = height_q;
      jump_pend_d  = jump_req;
      jump_pulse_d = 1'b0;
      land_pulse_d = 1'b0;
      if (!bus.alive) begin
         state_d     = StDead;
         jump_pend_d = 1'b0;
      end else if (state_q == StDead) begin
         state_d     = StGround;
         pos_d       = GROUND_Y;
         vel_d       = '0;
         height_d    = STAND_H;
         jump_pend_d = 1'b0;
      end else if (bus.frame_tick) begin
         jump_pend_d = 1'b0;
         case (state_q)
            StGround, StDuck: begin
               if (jump_req) begin
                  state_d      = StRise;
                  vel_d        = $signed({1'b0, JUMP_VEL});
                  pos_d        = GROUND_Y;
                  height_d     = STAND_H;
                  jump_pulse_d = 1'b1;
               end else if (duck_lvl) begin
                  // Shorter sprite pushed down so the feet stay on the ground line.
                  state_d  = StDuck;
                  pos_d    = GROUND_Y + CoordW'(STAND_H - DUCK_H);
                  height_d = DUCK_H;
               end else begin
                  state_d  = StGround;
                  pos_d    = GROUND_Y;
                  height_d = STAND_H;
               end
            end
            StRise, StFall: begin
               if (vel_q[VelW-1] && (next_y >= $signed({1'b0, GROUND_Y}))) begin
                  state_d      = StGround;
                  pos_d        = GROUND_Y;
                  vel_d        = '0;
                  land_pulse_d = 1'b1;
               end else if (next_y < $signed({1'b0, CEIL_Y})) begin
                  state_d = StFall;
                  pos_d   = CEIL_Y;
                  vel_d   = '0;
               end else begin
                  pos_d   = next_y[CoordW-1:0];
                  vel_d   = vel_next[VelW-1:0];
                  state_d = (!vel_next[VelW+1] && (vel_next != '0)) ? StRise : StFall;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge vgaclk) begin
      if (clr) begin
         state_q      <= StGround;
         vel_q        <= '0;
         pos_q        <= GROUND_Y;
         height_q     <= STAND_H;
         jump_pend_q  <= 1'b0;
         jump_pulse_q <= 1'b0;
         land_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         vel_q        <= vel_d;
         pos_q        <= pos_d;
         height_q     <= height_d;
         jump_pend_q  <= jump_pend_d;
         jump_pulse_q <= jump_pulse_d;
         land_pulse_q <= land_pulse_d;
      end
   end

   assign bus.dino_h      = DINO_X;
   assign bus.dino_v      = pos_q;
   assign bus.dino_height = height_q;
   assign bus.airborne    = (state_q == StRise) || (state_q == StFall);
   assign bus.jump_pulse  = jump_pulse_q;
   assign bus.land_pulse  = land_pulse_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Bench for dino_jump_ctrl: default instance plus a GROUND_Y=100 instance, driven identically.
module tb_dino_jump_ctrl;

   logic vgaclk = 1'b0;
   logic clr = 1'b1;
   logic frame_tick = 1'b0;
   logic jump_btn = 1'b0;
   logic duck_btn = 1'b0;
   logic alive = 1'b1;

   always #20 vgaclk = ~vgaclk;

   dino_jump_ctrl_if bus0 ();
   dino_jump_ctrl_if bus1 ();

   assign bus0.frame_tick = frame_tick;
   assign bus0.jump_btn   = jump_btn;
   assign bus0.duck_btn   = duck_btn;
   assign bus0.alive      = alive;
   assign bus1.frame_tick = frame_tick;
   assign bus1.jump_btn   = jump_btn;
   assign bus1.duck_btn   = duck_btn;
   assign bus1.alive      = alive;

   dino_jump_ctrl u_dut0 (
      .vgaclk (vgaclk),
      .clr    (clr),
      .bus    (bus0)
   );

   dino_jump_ctrl #(.GROUND_Y(10'd100)) u_dut1 (
      .vgaclk (vgaclk),
      .clr    (clr),
      .bus    (bus1)
   );

   localparam int DinoX = 80, StandH = 40, DuckH = 24, JumpVel = 14, MaxFall = 14;

   typedef struct {
      int h;
      int v;
      int ht;
      int air;
      int jp;
      int lp;
   } outs_t;

   typedef struct {
      int tick;
      int v0;
      int air0;
      int jp0;
      int lp0;
      int v1;
      int lp1;
   } vec_t;

   int    n_pass = 0;
   int    n_total = 0;
   int    gy [2] = '{380, 100};
   int    m_v [2], m_vel [2], m_h [2], m_air [2], e_jp [2], e_lp [2];
   bit    m_dead, m_pend;
   outs_t snap [2];
   vec_t  tbl [12];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   function automatic outs_t get_outs(input int i);
      outs_t o;
      if (i == 0) begin
         o.h = int'(bus0.dino_h);  o.v = int'(bus0.dino_v);   o.ht = int'(bus0.dino_height);
         o.air = int'(bus0.airborne); o.jp = int'(bus0.jump_pulse); o.lp = int'(bus0.land_pulse);
      end else begin
         o.h = int'(bus1.dino_h);  o.v = int'(bus1.dino_v);   o.ht = int'(bus1.dino_height);
         o.air = int'(bus1.airborne); o.jp = int'(bus1.jump_pulse); o.lp = int'(bus1.land_pulse);
      end
      return o;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_v[i] = gy[i]; m_vel[i] = 0; m_h[i] = StandH; m_air[i] = 0;
         e_jp[i] = 0; e_lp[i] = 0;
      end
      m_dead = 0;
      m_pend = 0;
   endfunction

   // Frame-level physics straight from the rules: ground/duck/jump, then flight with clamps.
   function automatic void model_tick();
      for (int i = 0; i < 2; i++) begin
         int ny;
         int dec;
         e_jp[i] = 0;
         e_lp[i] = 0;
         if (m_dead) continue;
         if (m_air[i] == 0) begin
            if (m_pend) begin
               m_air[i] = 1; m_vel[i] = JumpVel; m_v[i] = gy[i]; m_h[i] = StandH; e_jp[i] = 1;
            end else if (duck_btn) begin
               m_v[i] = gy[i] + StandH - DuckH; m_h[i] = DuckH;
            end else begin
               m_v[i] = gy[i]; m_h[i] = StandH;
            end
         end else begin
            ny = m_v[i] - m_vel[i];
`ifdef FAST_FALL_EN
            dec = duck_btn ? 2 : 1;
`else
            dec = 1;
`endif
            if (m_vel[i] < 0 && ny >= gy[i]) begin
               m_v[i] = gy[i]; m_vel[i] = 0; m_air[i] = 0; e_lp[i] = 1;
            end else if (ny < 0) begin
               m_v[i] = 0; m_vel[i] = 0;
            end else begin
               m_v[i] = ny;
               m_vel[i] = m_vel[i] - dec;
               if (m_vel[i] < -MaxFall) m_vel[i] = -MaxFall;
            end
         end
      end
      m_pend = 0;
   endfunction

   task automatic check_all(input string tag);
      for (int i = 0; i < 2; i++) begin
         outs_t o;
         o = get_outs(i);
         chk($sformatf("%s u%0d dino_h", tag, i), o.h, DinoX);
         chk($sformatf("%s u%0d dino_v", tag, i), o.v, m_v[i]);
         chk($sformatf("%s u%0d dino_height", tag, i), o.ht, m_h[i]);
         chk($sformatf("%s u%0d airborne", tag, i), o.air, m_dead ? 0 : m_air[i]);
         chk($sformatf("%s u%0d jump_pulse", tag, i), o.jp, e_jp[i]);
         chk($sformatf("%s u%0d land_pulse", tag, i), o.lp, e_lp[i]);
      end
   endtask

   // Tick well after any button change, check the registered result, then check pulses drop.
   task automatic do_tick(input string tag);
      repeat (5) @(negedge vgaclk);
      frame_tick = 1'b1;
      @(negedge vgaclk);
      frame_tick = 1'b0;
      model_tick();
      check_all(tag);
      snap[0] = get_outs(0);
      snap[1] = get_outs(1);
      @(negedge vgaclk);
      for (int i = 0; i < 2; i++) begin
         outs_t o;
         o = get_outs(i);
         chk($sformatf("%s u%0d jump_pulse width", tag, i), o.jp, 0);
         chk($sformatf("%s u%0d land_pulse width", tag, i), o.lp, 0);
      end
   endtask

   task automatic press_jump(input int ncyc);
      jump_btn = 1'b1;
      repeat (ncyc) @(negedge vgaclk);
      jump_btn = 1'b0;
      repeat (2) @(negedge vgaclk);
      if (!m_dead) m_pend = 1;
   endtask

   task automatic set_alive(input bit b);
      alive = b;
      if (!b) begin
         m_dead = 1; m_pend = 0;
      end else if (m_dead) begin
         model_reset();
      end
      @(negedge vgaclk);
      e_jp = '{0, 0};
      e_lp = '{0, 0};
      check_all(b ? "revive" : "die");
      repeat (3) @(negedge vgaclk);
   endtask

   task automatic do_clr(input string tag);
      clr = 1'b1;
      @(negedge vgaclk);
      model_reset();
      check_all(tag);
      clr = 1'b0;
      repeat (2) @(negedge vgaclk);
   endtask

   initial begin
      repeat (4000000) @(posedge vgaclk);
      $display("FAIL watchdog: cycle budget exhausted");
      $fatal(1, "watchdog");
   end

   initial begin
      // {tick, v0, air0, jp0, lp0, v_low, lp_low}; tick 0 is the jump tick.
      tbl = '{
         '{0, 380, 1, 1, 0, 100, 0}, '{1, 366, 1, 0, 0, 86, 0},
         '{2, 353, 1, 0, 0, 73, 0},  '{3, 341, 1, 0, 0, 61, 0},
         '{11, 281, 1, 0, 0, 1, 0},  '{12, 278, 1, 0, 0, 0, 0},
         '{13, 276, 1, 0, 0, 0, 0},  '{14, 275, 1, 0, 0, 1, 0},
         '{15, 275, 1, 0, 0, 3, 0},  '{27, 353, 1, 0, 0, 100, 1},
         '{28, 366, 1, 0, 0, 100, 0}, '{29, 380, 0, 0, 1, 100, 0}
      };
      model_reset();
      repeat (3) @(negedge vgaclk);
      check_all("reset");
      clr = 1'b0;
      repeat (2) @(negedge vgaclk);

      press_jump(1);
      for (int t = 0; t <= 30; t++) begin
         do_tick("jump");
         foreach (tbl[k]) begin
            if (tbl[k].tick == t) begin
               chk($sformatf("tbl t%0d v", t), snap[0].v, tbl[k].v0);
               chk($sformatf("tbl t%0d air", t), snap[0].air, tbl[k].air0);
               chk($sformatf("tbl t%0d jp", t), snap[0].jp, tbl[k].jp0);
               chk($sformatf("tbl t%0d lp", t), snap[0].lp, tbl[k].lp0);
               chk($sformatf("tbl t%0d low v", t), snap[1].v, tbl[k].v1);
               chk($sformatf("tbl t%0d low lp", t), snap[1].lp, tbl[k].lp1);
            end
         end
      end
      chk("landed air", snap[0].air, 0);

      press_jump(3);
      do_tick("held_press");
      chk("held_press jp", snap[0].jp, 1);
      repeat (4) do_tick("air");
      press_jump(1);
      repeat (40) do_tick("air_press");
      chk("air_press grounded", snap[0].air, 0);

      duck_btn = 1'b1;
      do_tick("duck");
      chk("duck height", snap[0].ht, 24);
      chk("duck v", snap[0].v, 396);
      duck_btn = 1'b0;
      do_tick("unduck");
      chk("unduck height", snap[0].ht, 40);
      chk("unduck v", snap[0].v, 380);
      duck_btn = 1'b1;
      press_jump(1);
      do_tick("duck_jump");
      chk("duck_jump v", snap[0].v, 380);
      chk("duck_jump air", snap[0].air, 1);
      repeat (35) do_tick("duck_air");
      duck_btn = 1'b0;
      do_tick("duck_done");

      press_jump(1);
      repeat (4) do_tick("pre_die");
      chk("pre_die v", snap[0].v, 341);
      set_alive(1'b0);
      for (int k = 0; k < 10; k++) begin
         press_jump(1);
         do_tick("dead");
         chk("dead frozen v", snap[0].v, 341);
      end
      set_alive(1'b1);
      press_jump(1);
      repeat (6) do_tick("pre_clr");
      do_clr("clr_mid_jump");

      for (int f = 0; f < 250; f++) begin
         if (m_dead) begin
            if ($urandom_range(0, 2) == 0) set_alive(1'b1);
         end else if ($urandom_range(0, 29) == 0) begin
            set_alive(1'b0);
         end
         if ($urandom_range(0, 3) == 0) duck_btn = !duck_btn;
         if (!m_dead && $urandom_range(0, 99) == 0) do_clr("rand_clr");
         if ($urandom_range(0, 4) == 0) press_jump(int'($urandom_range(1, 3)));
         do_tick("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
